// File: rtl/argon_bus_sequencer.sv
// argon_bus_sequencer
// Buffers 16-bit transfer descriptors in a small FIFO and issues them one at a
// time onto the shared master bus transfer-select lines. Each transfer waits for
// the bus source's valid strobe, bounded by a timeout that raises a sticky error.
//
// Ports:
//   i_Clk, i_Reset        clock (rising edge), synchronous active-high reset
//   i_desc/i_desc_valid   descriptor push {write_id, write_cmd, read_id, read_cmd}
//   o_desc_ready          FIFO not full
//   i_bus_valid           bus source produced data this cycle
//   o_write_id/command,
//   o_read_id/command     registered bus selects
//   o_busy                FSM not idle or FIFO non-empty
//   o_error, o_err_desc   sticky timeout flag and the descriptor that timed out
//   i_err_clear           leaves the error state
//   o_xfer_count          completed transfers (wraps)
module argon_bus_sequencer #(
  parameter int         DEPTH   = 4,
  parameter int         TIMEOUT = 8,
  parameter logic [3:0] IDLE_ID = 4'h0
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [15:0] i_desc,
  input  logic        i_desc_valid,
  output logic        o_desc_ready,
  input  logic        i_bus_valid,
  output logic [3:0]  o_write_id,
  output logic [3:0]  o_write_command,
  output logic [3:0]  o_read_id,
  output logic [3:0]  o_read_command,
  output logic        o_busy,
  output logic        o_error,
  output logic [15:0] o_err_desc,
  input  logic        i_err_clear,
  output logic [15:0] o_xfer_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ERROR
  } state_t;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [15:0]   IDLE_DESC = {IDLE_ID, 4'h0, IDLE_ID, 4'h0};

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  state_t        state;
  logic [15:0]   bus_q;
  logic [WW-1:0] wait_cnt;

  logic full;
  logic empty;
  logic do_push;
  logic do_pop;
  logic complete;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // No full-bypass: a pop in the same cycle does not make room for a push.
  assign o_desc_ready = !full;
  assign do_push      = i_desc_valid && !full;

  // A descriptor whose write_id is the idle ID only issues a command, so it
  // retires after one ISSUE cycle without waiting for the bus source.
  assign complete = (state == S_ISSUE) && (i_bus_valid || (bus_q[15:12] == IDLE_ID));
  assign do_pop   = !empty && ((state == S_IDLE) || complete);

  assign o_busy = (state != S_IDLE) || !empty;

  assign o_write_id      = bus_q[15:12];
  assign o_write_command = bus_q[11:8];
  assign o_read_id       = bus_q[7:4];
  assign o_read_command  = bus_q[3:0];

  // NOTE: FIFO storage has no reset; only the pointers and count define which
  // entries are valid, so clearing the array would cost logic for nothing.
  always_ff @(posedge i_Clk) begin
    if (do_push) begin
      mem[wr_ptr] <= i_desc;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every branch reads
  // the pre-edge values of count, state and bus_q.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      state        <= S_IDLE;
      bus_q        <= IDLE_DESC;
      wait_cnt     <= '0;
      o_error      <= 1'b0;
      o_err_desc   <= '0;
      o_xfer_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);

      case (state)
        S_IDLE: begin
          if (!empty) begin
            bus_q    <= mem[rd_ptr];
            wait_cnt <= '0;
            state    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // Completion is tested before the timeout, so valid wins the race.
          if (complete) begin
            o_xfer_count <= o_xfer_count + 16'd1;
            wait_cnt     <= '0;
            if (!empty) begin
              bus_q <= mem[rd_ptr];
            end else begin
              bus_q <= IDLE_DESC;
              state <= S_IDLE;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            o_error    <= 1'b1;
            o_err_desc <= bus_q;
            bus_q      <= IDLE_DESC;
            state      <= S_ERROR;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end

        S_ERROR: begin
          if (i_err_clear) begin
            o_error <= 1'b0;
            state   <= S_IDLE;
          end
        end

        default: begin
          bus_q <= IDLE_DESC;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argon_bus_sequencer.sv
// Self-checking bench for argon_bus_sequencer (DEPTH=4, TIMEOUT=8, IDLE_ID=0).
// A table of single transfers covers the issue/complete path; hand-written
// sequences cover back-to-back issue, FIFO full, timeout and reset.
module tb_argon_bus_sequencer;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic [15:0] i_desc;
  logic        i_desc_valid;
  logic        o_desc_ready;
  logic        i_bus_valid;
  logic [3:0]  o_write_id;
  logic [3:0]  o_write_command;
  logic [3:0]  o_read_id;
  logic [3:0]  o_read_command;
  logic        o_busy;
  logic        o_error;
  logic [15:0] o_err_desc;
  logic        i_err_clear;
  logic [15:0] o_xfer_count;

  int checks = 0;
  int errors = 0;

  argon_bus_sequencer #(
    .DEPTH  (4),
    .TIMEOUT(8),
    .IDLE_ID(4'h0)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Reset        (i_Reset),
    .i_desc         (i_desc),
    .i_desc_valid   (i_desc_valid),
    .o_desc_ready   (o_desc_ready),
    .i_bus_valid    (i_bus_valid),
    .o_write_id     (o_write_id),
    .o_write_command(o_write_command),
    .o_read_id      (o_read_id),
    .o_read_command (o_read_command),
    .o_busy         (o_busy),
    .o_error        (o_error),
    .o_err_desc     (o_err_desc),
    .i_err_clear    (i_err_clear),
    .o_xfer_count   (o_xfer_count)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic [15:0] desc;
    int          stall;   // ISSUE cycles with bus valid low before it rises
    logic [3:0]  wid;
    logic [3:0]  wcmd;
    logic [3:0]  rid;
    logic [3:0]  rcmd;
    int          cycles;  // expected ISSUE cycles occupied
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] bus();
    return {o_write_id, o_write_command, o_read_id, o_read_command};
  endfunction

  task automatic push(input logic [15:0] d);
    i_desc       = d;
    i_desc_valid = 1'b1;
    tick();
    i_desc_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] fill [6];
    int          exp_count;
    int          cyc;

    vecs[0] = '{desc: 16'h1325, stall: 0, wid: 4'h1, wcmd: 4'h3, rid: 4'h2, rcmd: 4'h5, cycles: 1};
    vecs[1] = '{desc: 16'hA5F0, stall: 3, wid: 4'hA, wcmd: 4'h5, rid: 4'hF, rcmd: 4'h0, cycles: 4};
    vecs[2] = '{desc: 16'h0017, stall: 5, wid: 4'h0, wcmd: 4'h0, rid: 4'h1, rcmd: 4'h7, cycles: 1};
    vecs[3] = '{desc: 16'h2310, stall: 7, wid: 4'h2, wcmd: 4'h3, rid: 4'h1, rcmd: 4'h0, cycles: 8};
    vecs[4] = '{desc: 16'hFFFF, stall: 0, wid: 4'hF, wcmd: 4'hF, rid: 4'hF, rcmd: 4'hF, cycles: 1};
    fill = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    exp_count = 0;

    // ---- Reset with random inputs ----
    i_Reset      = 1'b1;
    i_desc       = 16'($urandom);
    i_desc_valid = 1'($urandom);
    i_bus_valid  = 1'($urandom);
    i_err_clear  = 1'($urandom);
    tick();
    i_desc       = 16'($urandom);
    i_desc_valid = 1'($urandom);
    i_bus_valid  = 1'($urandom);
    tick();
    check("reset_bus", 32'(bus()), 32'h0);
    check("reset_error", 32'(o_error), 32'h0);
    check("reset_err_desc", 32'(o_err_desc), 32'h0);
    check("reset_count", 32'(o_xfer_count), 32'h0);
    check("reset_ready", 32'(o_desc_ready), 32'h1);
    check("reset_busy", 32'(o_busy), 32'h0);
    i_Reset      = 1'b0;
    i_desc       = '0;
    i_desc_valid = 1'b0;
    i_bus_valid  = 1'b0;
    i_err_clear  = 1'b1;  // must have no effect outside ERROR
    tick();
    check("idle_bus", 32'(bus()), 32'h0);

    // ---- Table-driven single transfers ----
    for (int v = 0; v < 5; v++) begin
      push(vecs[v].desc);
      check($sformatf("v%0d_latency_idle", v), 32'(bus()), 32'h0);
      tick();
      check($sformatf("v%0d_busy", v), 32'(o_busy), 32'h1);
      cyc = 0;
      while (o_busy && cyc < 20) begin
        check($sformatf("v%0d_bus_c%0d", v, cyc), 32'(bus()),
              32'({vecs[v].wid, vecs[v].wcmd, vecs[v].rid, vecs[v].rcmd}));
        i_bus_valid = (cyc >= vecs[v].stall);
        tick();
        cyc++;
      end
      i_bus_valid = 1'b0;
      exp_count++;
      check($sformatf("v%0d_cycles", v), 32'(cyc), 32'(vecs[v].cycles));
      check($sformatf("v%0d_count", v), 32'(o_xfer_count), 32'(exp_count));
      check($sformatf("v%0d_idle", v), 32'(bus()), 32'h0);
      check($sformatf("v%0d_error", v), 32'(o_error), 32'h0);
    end
    i_err_clear = 1'b0;

    // ---- Back-to-back with bus valid held high ----
    i_bus_valid = 1'b1;
    push(16'h1325);
    push(16'h2131);
    check("b2b_first", 32'(bus()), 32'h1325);
    push(16'h3402);
    check("b2b_second", 32'(bus()), 32'h2131);
    tick();
    check("b2b_third", 32'(bus()), 32'h3402);
    tick();
    exp_count += 3;
    check("b2b_idle", 32'(bus()), 32'h0);
    check("b2b_count", 32'(o_xfer_count), 32'(exp_count));
    check("b2b_busy", 32'(o_busy), 32'h0);
    i_bus_valid = 1'b0;

    // ---- Full FIFO: 6 offered, 5 accepted ----
    for (int i = 0; i < 6; i++) begin
      i_desc       = fill[i];
      i_desc_valid = 1'b1;
      check($sformatf("full_ready_%0d", i), 32'(o_desc_ready), 32'(i < 5));
      tick();
    end
    check("full_ready_after", 32'(o_desc_ready), 32'h0);
    check("full_head", 32'(bus()), 32'h1111);
    i_desc_valid = 1'b0;
    i_bus_valid  = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      check($sformatf("drain_%0d", i), 32'(bus()), 32'(fill[i]));
    end
    tick();
    exp_count += 5;
    check("drain_idle", 32'(bus()), 32'h0);
    check("drain_busy", 32'(o_busy), 32'h0);
    check("drain_count", 32'(o_xfer_count), 32'(exp_count));
    i_bus_valid = 1'b0;

    // ---- Timeout, queued descriptor held until clear ----
    push(16'h2310);
    tick();                       // ISSUE cycle 1
    check("to_issue", 32'(bus()), 32'h2310);
    i_desc       = 16'h4455;
    i_desc_valid = 1'b1;
    tick();                       // ISSUE cycle 2, 16'h4455 queued
    i_desc_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();   // ISSUE cycle 8
    check("to_before", 32'(o_error), 32'h0);
    check("to_before_bus", 32'(bus()), 32'h2310);
    tick();
    check("to_error", 32'(o_error), 32'h1);
    check("to_err_desc", 32'(o_err_desc), 32'h2310);
    check("to_bus_idle", 32'(bus()), 32'h0);
    check("to_busy", 32'(o_busy), 32'h1);
    check("to_count", 32'(o_xfer_count), 32'(exp_count));
    i_bus_valid = 1'b1;           // must not resume issuing while in ERROR
    check("to_ready_in_error", 32'(o_desc_ready), 32'h1);
    push(16'h5566);               // accepted while in ERROR
    tick();
    tick();
    check("to_held_bus", 32'(bus()), 32'h0);
    check("to_held_error", 32'(o_error), 32'h1);
    i_err_clear = 1'b1;
    tick();
    i_err_clear = 1'b0;
    check("clr_error", 32'(o_error), 32'h0);
    check("clr_err_desc", 32'(o_err_desc), 32'h2310);
    check("clr_bus", 32'(bus()), 32'h0);
    tick();
    check("clr_issue1", 32'(bus()), 32'h4455);
    tick();
    check("clr_issue2", 32'(bus()), 32'h5566);
    tick();
    exp_count += 2;
    check("clr_idle", 32'(bus()), 32'h0);
    check("clr_count", 32'(o_xfer_count), 32'(exp_count));
    check("clr_busy", 32'(o_busy), 32'h0);
    i_bus_valid = 1'b0;

    // ---- Mid-transfer reset ----
    push(16'h7788);
    push(16'h99AA);
    tick();
    check("mr_issue", 32'(bus()), 32'h7788);
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    check("mr_bus", 32'(bus()), 32'h0);
    check("mr_count", 32'(o_xfer_count), 32'h0);
    check("mr_busy", 32'(o_busy), 32'h0);
    check("mr_ready", 32'(o_desc_ready), 32'h1);
    check("mr_error", 32'(o_error), 32'h0);
    check("mr_err_desc", 32'(o_err_desc), 32'h0);
    tick();
    tick();
    check("mr_fifo_empty_bus", 32'(bus()), 32'h0);
    check("mr_fifo_empty_busy", 32'(o_busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/argon_bus_sequencer.md
# argon_bus_sequencer

Drives the shared master bus's transfer-select lines: `write_id`, `write_command`, `read_id` and `read_command`. It replaces the tie-off ports the control unit currently owns in the top level. The block accepts 16-bit transfer descriptors through a valid/ready handshake and buffers them in a small FIFO. It then issues them one transfer at a time, waiting for the bus source's `o_valid`, with a timeout and a sticky error. It sits directly upstream of the bus mux, feeding the ALU/RegFile/Stack/Debug unit selection.

## Interface
- `DEPTH`, 4: descriptor FIFO entries; power of two, ≥2.
- `TIMEOUT`, 8: ISSUE cycles without `i_bus_valid` before error; ≥1.
- `IDLE_ID`, 4'h0: unit ID driven when idle; must not match any unit ID.

Ports:
- `i_Clk`  in  1  clock; all logic on rising edge.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_desc`  in  16  descriptor, laid out as [15:12] write_id, [11:8] write_command, [7:4] read_id, [3:0] read_command.
- `i_desc_valid`  in  1  descriptor offered.
- `o_desc_ready`  out  1  FIFO can accept; equals !full.
- `i_bus_valid`  in  1  master bus `o_valid` (source produced data this cycle).
- `o_write_id`, `o_write_command`, `o_read_id`, `o_read_command`  out  4 each  registered bus selects.
- `o_busy`  out  1  state != IDLE or FIFO non-empty.
- `o_error`  out  1  sticky timeout flag.
- `o_err_desc`  out  16  descriptor that timed out.
- `i_err_clear`  in  1  single-cycle pulse that leaves ERROR.
- `o_xfer_count`  out  16  completed transfers; wraps at 2^16.

## Operation
- **Push.** A descriptor is written into the FIFO on an edge where `i_desc_valid && o_desc_ready`. When the FIFO is full, ready is low even if a pop happens that cycle; there is no full-bypass.
- **FSM state IDLE.** Bus outputs are `IDLE_ID`/0/`IDLE_ID`/0. If the FIFO is non-empty: pop the head, load the output registers from it, clear the wait counter, and go to ISSUE.
- **FSM state ISSUE.** Outputs hold the current descriptor. Transfer completion depends on the descriptor type:
  - **Normal transfer.** Completes on an edge where `i_bus_valid=1`.
  - **Command-only descriptor** (write_id == `IDLE_ID`). Completes after exactly one ISSUE cycle, regardless of `i_bus_valid`.
- **On completion.**
  - `o_xfer_count` increments.
  - If the FIFO is non-empty, pop the next descriptor into the outputs on the same edge and stay in ISSUE (zero-bubble back-to-back).
  - Otherwise, clear the outputs to idle values and go to IDLE.
- **Wait counter.** The counter increments on each ISSUE cycle that does not complete the transfer. If it equals `TIMEOUT-1` and the transfer does not complete on that edge, the FSM moves to ERROR.
- **Race rule.** If `i_bus_valid` arrives on the same cycle the timeout would fire, the transfer completes; valid wins.
- **FSM state ERROR.**
  - Entry: `o_error=1`, `o_err_desc` is set to the failed descriptor, and outputs return to idle values.
  - While in ERROR: the FIFO keeps accepting descriptors but none are issued.
  - Exit: `i_err_clear=1` clears `o_error` and moves the FSM to IDLE; `o_err_desc` holds its value.
- `i_err_clear` has no effect outside ERROR.
- **Reset.** A synchronous reset from any state, including mid-transfer, empties the FIFO and forces IDLE. Every output goes to: `o_write_id`=`o_read_id`=`IDLE_ID`, commands=0, `o_error`=0, `o_err_desc`=0, `o_xfer_count`=0, `o_busy`=0, `o_desc_ready`=1.

## Timing
- **Push-to-bus latency (empty FIFO, IDLE).** A descriptor accepted at edge N is popped at edge N+1. Bus selects are valid in the cycle after edge N+1, so the latency is 2 edges.
- **Back-to-back issue.** Consecutive descriptors occupy consecutive bus cycles while `i_bus_valid` stays high.
- **Per-descriptor bound.** One descriptor occupies between 1 and `TIMEOUT` ISSUE cycles.
- **Counter and busy update.** `o_xfer_count` updates on the completion edge. `o_busy` is combinational from state and FIFO count.
- **Output registration.** All bus-select outputs are registered; the downstream mux sees no combinational path from `i_desc`.

## Test plan
1. **Reset.** Hold `i_Reset` for 2 cycles with random inputs. Required: ids=0, commands=0, error=0, count=0, ready=1, busy=0.
2. **Single transfer.** Push 16'h1325, then pulse `i_bus_valid` on the first ISSUE cycle.
   - Bus selects show write_id=1, wcmd=3, read_id=2, rcmd=5 for exactly 1 cycle.
   - They then return to 0; count=1; busy=0.
3. **Back-to-back.** Push 16'h1325, 16'h2131 and 16'h3402 with `i_bus_valid` held at 1. Required: three consecutive ISSUE cycles with no idle cycle between them, then count=3.
4. **Full FIFO.** Hold `i_bus_valid`=0 and offer 6 descriptors on consecutive cycles.
   - 5 are accepted (1 issuing, 4 queued); ready drops after the 5th; the 6th is held.
   - Raising `i_bus_valid` drains all entries in order.
5. **Timeout.** With TIMEOUT=8 and `i_bus_valid`=0, push 16'h2310.
   - After 8 ISSUE cycles: error=1, err_desc=16'h2310, outputs idle.
   - A queued descriptor is not issued until `i_err_clear`; after the clear it issues.
   - Variant: assert valid on the 8th ISSUE cycle. Required: transfer completes, no error.
6. **Command-only and mid-transfer reset.**
   - Push 16'h0017 with `i_bus_valid`=0. Required: it completes after 1 cycle and count increments.
   - Then start a stalled transfer and reset mid-ISSUE. Required: all reset values on the next cycle, and the FIFO is empty.
